leb128_encoder: RTL and testbench
=================================

// Module: leb128_encoder
// PURPOSE
//   Serialises one typed WebAssembly constant into its bytecode immediate
//   encoding, one byte per cycle. Signed or unsigned LEB128 for `i32/`i64;
//   raw little-endian bytes for `f32/`f64. It is the writer side of the
//   immediate decoder in cpu: it builds bytecode streams for ROM images and
//   feeds loaders. Type codes come from cpu.vh.
// PARAMETERS
//   OPCODE_I32  8'h41  prefix byte for `i32 (used only with LEB128_ENC_OPCODE_EN)
//   OPCODE_I64  8'h42  prefix byte for `i64
//   OPCODE_F32  8'h43  prefix byte for `f32
//   OPCODE_F64  8'h44  prefix byte for `f64
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   in_valid   in   1   in_value/in_type/in_signed are valid
//   in_ready   out  1   encoder idle; accepts a value when in_valid is also high
//   in_value   in   64  value; `i32/`f32 use bits [31:0] only
//   in_type    in   2   `i32/`i64/`f32/`f64
//   in_signed  in   1   1 = signed LEB128, 0 = unsigned; ignored for floats
//   out_valid  out  1   out_data holds a byte
//   out_ready  in   1   sink takes the byte when out_valid is also high
//   out_data   out  8   encoded byte
//   out_last   out  1   out_data is the final byte of this value
//   out_count  out  4   index of the current byte within the value (0..10)
// BEHAVIOUR
//   - Reset (asynchronous, while reset==0): state IDLE, in_ready=1, out_valid=0,
//     out_data=0, out_last=0, out_count=0. Reset mid-value drops the value and
//     any partly sent bytes; out_valid falls at once, with no clock edge needed.
//   - FSM: IDLE -> EMIT (or IDLE -> PREFIX -> EMIT when the option is on) -> IDLE.
//     in_ready = (state==IDLE). The input handshake latches the value, and
//     out_valid=1 on the next cycle. Latency: 1 cycle from input to first byte.
//   - Latch rule: for `i32, in_value[31:0] is sign-extended (in_signed=1) or
//     zero-extended to 64 bits; upper input bits are ignored.
//   - LEB byte = {more, v[6:0]}; then v becomes v>>>7 (signed) or v>>7 (unsigned).
//     Signed stops when the remaining v==0 and byte bit6==0, or when v==-1 and
//     bit6==1. Unsigned stops when the remaining v==0. Bounds: `i32 at most 5
//     bytes, `i64 at most 10 bytes.
//   - Floats: exactly 4 (`f32) or 8 (`f64) bytes, least significant byte first,
//     never a continuation bit.
//   - While out_valid && !out_ready, out_data, out_last and out_count hold steady.
//     Each output handshake advances one byte, so with out_ready held high
//     throughput is 1 byte per cycle.
//   - Handshake on a byte with out_last=1: go to IDLE, out_valid=0 and in_ready=1
//     on the next cycle. There is no same-cycle overlap between values: at least
//     one bubble cycle follows each value.
//   - in_value, in_type and in_signed are don't-care unless in_valid && in_ready.
// CONFIGURATION
//   LEB128_ENC_OPCODE_EN defined: before the immediate, emit one prefix byte
//     chosen by in_type (OPCODE_*). out_count=0 on the prefix; the immediate
//     bytes start at 1. The result is a full *.const instruction.
//   Not defined: immediate bytes only; the PREFIX state and the parameters are
//     unused.
// TESTING
//   1. `i64 3, signed, out_ready=1 -> single byte 0x03, out_last=1, then in_ready=1
//      two cycles after acceptance.
//   2. `i32 0xFFFFFFFF signed -> 0x7F last. The same value unsigned ->
//      FF FF FF FF 0F, with out_last on the 5th byte.
//   3. `i32 64 signed -> C0 00; `i64 624485 unsigned -> E5 8E 26.
//   4. `i64 0x8000000000000000 signed -> 80 x9 then 7F; out_count 0..9;
//      out_last only at 9.
//   5. `f32 0x3F800000 with out_ready low for 3 cycles on byte 2 -> 00 00 80 3F;
//      byte 2 held stable; no byte lost or duplicated.
//   6. Drop reset low during byte 4 of case 4 -> out_valid=0 at once; after
//      release in_ready=1; a new `i64 3 gives 0x03.
//      With LEB128_ENC_OPCODE_EN defined, case 1 gives 42 03.

Source files
------------

// File: rtl/leb128_encoder_if.sv
// Byte-stream handshake bundle for leb128_encoder.
// slave = encoder side, master = producer/sink side.
interface leb128_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [1:0]  in_type;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [3:0]  out_count;

  modport slave (
    input  in_valid, in_value, in_type, in_signed,
    input  out_ready,
    output in_ready,
    output out_valid, out_data, out_last, out_count
  );

  modport master (
    output in_valid, in_value, in_type, in_signed,
    output out_ready,
    input  in_ready,
    input  out_valid, out_data, out_last, out_count
  );
endinterface

// File: rtl/leb128_encoder.sv
// LEB128 / raw-float immediate serialiser, one byte per cycle.
// Option macro LEB128_ENC_OPCODE_EN adds a *.const opcode prefix byte.
`ifndef TY_I32
`define TY_I32 2'd0
`endif
`ifndef TY_I64
`define TY_I64 2'd1
`endif
`ifndef TY_F32
`define TY_F32 2'd2
`endif
`ifndef TY_F64
`define TY_F64 2'd3
`endif

module leb128_encoder #(
  parameter logic [7:0] OPCODE_I32 = 8'h41,
  parameter logic [7:0] OPCODE_I64 = 8'h42,
  parameter logic [7:0] OPCODE_F32 = 8'h43,
  parameter logic [7:0] OPCODE_F64 = 8'h44
) (
  input logic             clk,
  input logic             reset,
  leb128_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    EMIT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] val;
  logic [63:0] val_in;
  logic [63:0] shr;
  logic [1:0]  typ;
  logic        sgn;
  logic [3:0]  cnt;
  logic [3:0]  idx;
  logic [7:0]  pfx;
  logic        is_flt;
  logic        leb_done;
  logic        flt_done;
  logic        cap;
  logic        last;
  logic        accept;
  logic        fire;

  assign accept = bus.in_valid && (state == IDLE);
  assign fire   = bus.out_ready && (state != IDLE);
  assign is_flt = (typ == `TY_F32) || (typ == `TY_F64);

`ifdef LEB128_ENC_OPCODE_EN
  assign idx = cnt - 4'd1;
`else
  assign idx = cnt;
`endif

  always_comb begin
    val_in = bus.in_value;
    unique case (bus.in_type)
      `TY_I32: val_in = {{32{bus.in_signed & bus.in_value[31]}},
                         bus.in_value[31:0]};
      `TY_F32: val_in = {32'd0, bus.in_value[31:0]};
      default: ;
    endcase
  end

  always_comb begin
    pfx = OPCODE_I32;
    unique case (typ)
      `TY_I64: pfx = OPCODE_I64;
      `TY_F32: pfx = OPCODE_F32;
      `TY_F64: pfx = OPCODE_F64;
      default: ;
    endcase
  end

  // shr is the value left after the current byte goes out
  always_comb begin
    if (is_flt)
      shr = val >> 8;
    else if (sgn)
      shr = $unsigned($signed(val) >>> 7);
    else
      shr = val >> 7;
  end

  assign leb_done = sgn
    ? ((shr == '0 && !val[6]) || (&shr && val[6]))
    : (shr == '0);
  assign flt_done = idx == ((typ == `TY_F32) ? 4'd3 : 4'd7);
  assign cap      = idx == ((typ == `TY_I32) ? 4'd4 : 4'd9);
  assign last     = (state == EMIT)
    && (is_flt ? flt_done : (leb_done || cap));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.in_valid)
`ifdef LEB128_ENC_OPCODE_EN
          state_nxt = PREFIX;
`else
          state_nxt = EMIT;
`endif
      PREFIX:
        if (bus.out_ready) state_nxt = EMIT;
      EMIT:
        if (bus.out_ready && last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = 1'b0;
    bus.out_data  = 8'd0;
    bus.out_last  = 1'b0;
    bus.out_count = 4'd0;
    unique case (state)
      PREFIX: begin
        bus.out_valid = 1'b1;
        bus.out_data  = pfx;
        bus.out_count = cnt;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = is_flt ? val[7:0]
                               : {!(leb_done || cap), val[6:0]};
        bus.out_last  = last;
        bus.out_count = cnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val <= '0;
      typ <= 2'd0;
      sgn <= 1'b0;
      cnt <= 4'd0;
    end else if (accept) begin
      val <= val_in;
      typ <= bus.in_type;
      sgn <= bus.in_signed
        && (bus.in_type != `TY_F32) && (bus.in_type != `TY_F64);
      cnt <= 4'd0;
    end else if (fire) begin
      cnt <= last ? 4'd0 : cnt + 4'd1;
      if (state == EMIT) val <= shr;
    end
  end

endmodule

// File: tb/tb_leb128_encoder.sv
// Scoreboard bench for leb128_encoder: directed vectors,
// expected bytes queued at issue, checked by an output monitor.
`ifndef TY_I32
`define TY_I32 2'd0
`endif
`ifndef TY_I64
`define TY_I64 2'd1
`endif
`ifndef TY_F32
`define TY_F32 2'd2
`endif
`ifndef TY_F64
`define TY_F64 2'd3
`endif

module tb_leb128_encoder;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [3:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  leb128_encoder_if bus();

  leb128_encoder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t       sb[$];
  logic [7:0] bq[$];
  int         errors = 0;
  int         checks = 0;
  int         off;
  bit         stall = 1'b0;
  exp_t       held;

`ifdef LEB128_ENC_OPCODE_EN
  initial off = 1;
`else
  initial off = 0;
`endif

  task automatic check(string nm, logic [63:0] act,
                       logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] opc(logic [1:0] t);
    case (t)
      `TY_I32: return 8'h41;
      `TY_I64: return 8'h42;
      `TY_F32: return 8'h43;
      default: return 8'h44;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall = 1'b0;
    end else begin
      if (stall && bus.out_valid) begin
        check("hold_data", 64'(bus.out_data), 64'(held.d));
        check("hold_last", 64'(bus.out_last), 64'(held.l));
        check("hold_count", 64'(bus.out_count), 64'(held.c));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected none",
                   bus.out_data);
        end else begin
          e = sb.pop_front();
          check("byte", 64'(bus.out_data), 64'(e.d));
          check("last", 64'(bus.out_last), 64'(e.l));
          check("count", 64'(bus.out_count), 64'(e.c));
        end
        stall = 1'b0;
      end else if (bus.out_valid) begin
        stall  = 1'b1;
        held.d = bus.out_data;
        held.l = bus.out_last;
        held.c = bus.out_count;
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic send(logic [63:0] v, logic [1:0] t, logic s);
    exp_t e;
    int   n;
    if (off == 1) begin
      e.d = opc(t);
      e.l = 1'b0;
      e.c = 4'd0;
      sb.push_back(e);
    end
    foreach (bq[i]) begin
      e.d = bq[i];
      e.l = (i == bq.size() - 1);
      e.c = 4'(i + off);
      sb.push_back(e);
    end
    bq.delete();
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_value  = v;
    bus.in_type   = t;
    bus.in_signed = s;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_value  = {$urandom, $urandom};
    bus.in_signed = ~s;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_idx(int c);
    int n = 0;
    while (!(bus.out_valid && bus.out_count == 4'(c))
           && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idx", 64'(bus.out_count), 64'(c));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.in_type   = `TY_I32;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    bq = '{8'h03};
    send(64'd3, `TY_I64, 1'b1);
    if (off == 0) begin
      check("c1_valid", 64'(bus.out_valid), 64'd1);
      check("c1_last", 64'(bus.out_last), 64'd1);
      check("c1_busy", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("c1_idle_ready", 64'(bus.in_ready), 64'd1);
      check("c1_idle_valid", 64'(bus.out_valid), 64'd0);
    end
    drain("c1_drain");

    bq = '{8'h7F};
    send(64'hDEADBEEF_FFFFFFFF, `TY_I32, 1'b1);
    drain("c2s_drain");
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    send(64'hDEADBEEF_FFFFFFFF, `TY_I32, 1'b0);
    drain("c2u_drain");

    bq = '{8'hC0, 8'h00};
    send(64'd64, `TY_I32, 1'b1);
    drain("c3a_drain");
    bq = '{8'hE5, 8'h8E, 8'h26};
    send(64'd624485, `TY_I64, 1'b0);
    drain("c3b_drain");

    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
           8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
    send(64'h80000000_00000000, `TY_I64, 1'b1);
    drain("c4_drain");

    bq = '{8'h00, 8'h00, 8'h80, 8'h3F};
    send(64'h3F800000, `TY_F32, 1'b1);
    wait_idx(2 + off);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("c5_stall_count", 64'(bus.out_count), 64'(2 + off));
    check("c5_stall_data", 64'(bus.out_data), 64'h80);
    bus.out_ready = 1'b1;
    drain("c5_drain");

    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
           8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
    send(64'h80000000_00000000, `TY_I64, 1'b1);
    wait_idx(4 + off);
    reset = 1'b0;
    #1;
    check("c6_async_valid", 64'(bus.out_valid), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("c6_ready", 64'(bus.in_ready), 64'd1);
    bq = '{8'h03};
    send(64'd3, `TY_I64, 1'b1);
    drain("c6_drain");

    bq = '{8'hEF, 8'hCD, 8'hAB, 8'h89,
           8'h67, 8'h45, 8'h23, 8'h01};
    send(64'h01234567_89ABCDEF, `TY_F64, 1'b1);
    drain("f64_drain");
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    send(64'hFFFFFFFF_FFFFFFFF, `TY_I64, 1'b0);
    drain("u64max_drain");
    bq = '{8'h40};
    send(64'h00000000_FFFFFFC0, `TY_I32, 1'b1);
    drain("neg64_drain");
    bq = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78};
    send(64'h00000000_80000000, `TY_I32, 1'b1);
    drain("i32min_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
